// File: rtl/pool_wb_pkg.sv
// Shared types for the pooled-result write-back arbiter: FSM states, FIFO entry layout
// and the helper that packs one pool lane into a FIFO entry.
package pool_wb_pkg;

  localparam int unsigned PW_DATA_W  = 8;
  localparam int unsigned PW_PADDR_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [PW_PADDR_W-1:0] addr;
    logic [PW_DATA_W-1:0]  data;
  } entry_t;

  function automatic entry_t mk_entry(
    input logic                  last,
    input logic [PW_PADDR_W-1:0] addr,
    input logic [PW_DATA_W-1:0]  data
  );
    entry_t e;
    e.last = last;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/pool_wb_fifo.sv
// Synchronous per-pool FIFO of entry_t; push is ignored when full, pop when empty.
// Storage has no reset: clearing the pointers and count discards the contents.
module pool_wb_fifo
  import pool_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  entry_t           i_din,
  input  logic             i_pop,
  output entry_t           o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  entry_t           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pool_wb_arbiter.sv
// Funnels POOL_NUM pooled-result streams through per-pool FIFOs and a round-robin arbiter
// into one BRAM write port; tracks per-channel last flags and pulses done_o at layer end.
module pool_wb_arbiter
  import pool_wb_pkg::*;
#(
  parameter int unsigned POOL_NUM   = 6,
  parameter int unsigned DATA_WIDTH = PW_DATA_W,
  parameter int unsigned PADDR_W    = PW_PADDR_W,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned CH_SHIFT   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [POOL_NUM-1:0]            ch_en_i,
  input  logic [ADDR_W-1:0]              out_base_i,
  input  logic [POOL_NUM-1:0]            pool_valid_i,
  input  logic [POOL_NUM-1:0]            pool_last_i,
  input  logic [POOL_NUM*DATA_WIDTH-1:0] pool_data_i,
  input  logic [POOL_NUM*PADDR_W-1:0]    pool_addr_i,
  output logic [POOL_NUM-1:0]            pool_ready_o,
  output logic                           wea_o,
  output logic [ADDR_W-1:0]              addra_o,
  output logic [DATA_WIDTH-1:0]          dia_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [POOL_NUM-1:0]            overflow_o,
  output logic [15:0]                    wr_count_o
);

  localparam int unsigned IDX_W = (POOL_NUM > 1) ? $clog2(POOL_NUM) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  logic [POOL_NUM-1:0]   r_ch_en;
  logic [POOL_NUM-1:0]   r_last_seen;
  logic [ADDR_W-1:0]     r_base;
  logic [IDX_W-1:0]      r_rr;
  logic                  r_wea;
  logic [ADDR_W-1:0]     r_addra;
  logic [DATA_WIDTH-1:0] r_dia;
  logic                  r_busy;
  logic                  r_done;
  logic [POOL_NUM-1:0]   r_ovf;
  logic [15:0]           r_wr_count;

  logic                  w_accept;
  logic [POOL_NUM-1:0]   w_push;
  logic [POOL_NUM-1:0]   w_pop;
  logic [POOL_NUM-1:0]   w_full;
  logic [POOL_NUM-1:0]   w_empty;
  logic [POOL_NUM-1:0]   w_ovf;
  logic [CNT_W-1:0]      w_count [POOL_NUM];
  entry_t                w_din   [POOL_NUM];
  entry_t                w_dout  [POOL_NUM];
  logic                  w_gnt_vld;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W-1:0]      w_scan;
  entry_t                w_gnt_entry;
  logic                  w_all_last;

  assign w_accept = (r_state != S_IDLE);

  for (genvar k = 0; k < POOL_NUM; k++) begin : g_pool
    assign w_din[k] = mk_entry(pool_last_i[k],
                               pool_addr_i[k*PADDR_W +: PADDR_W],
                               pool_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
    // A full FIFO rejects the push even if it is being popped this same cycle.
    assign w_push[k]       = pool_valid_i[k] & r_ch_en[k] & w_accept & ~w_full[k];
    assign w_ovf[k]        = pool_valid_i[k] & r_ch_en[k] & w_accept & w_full[k];
    assign w_pop[k]        = w_gnt_vld & (w_gnt_idx == IDX_W'(k));
    assign pool_ready_o[k] = (w_count[k] != CNT_W'(FIFO_DEPTH));

    pool_wb_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[k]),
      .i_din   (w_din[k]),
      .i_pop   (w_pop[k]),
      .o_dout  (w_dout[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_count (w_count[k])
    );
  end

  // Scan starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr;
    w_scan    = '0;
    for (int unsigned i = 1; i <= POOL_NUM; i++) begin
      w_scan = IDX_W'((32'(r_rr) + i) % POOL_NUM);
      if (!w_gnt_vld && !w_empty[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_gnt_entry = w_dout[w_gnt_idx];
  assign w_all_last  = &(r_last_seen | ~r_ch_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_en     <= '0;
      r_last_seen <= '0;
      r_base      <= '0;
      r_rr        <= '0;
      r_wea       <= 1'b0;
      r_addra     <= '0;
      r_dia       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= '0;
      r_wr_count  <= '0;
    end else begin
      r_wea  <= w_gnt_vld;
      r_done <= 1'b0;
      r_ovf  <= r_ovf | w_ovf;
      if (w_gnt_vld) begin
        r_addra <= r_base + (ADDR_W'(w_gnt_idx) << CH_SHIFT) + ADDR_W'(w_gnt_entry.addr);
        r_dia   <= w_gnt_entry.data;
        r_rr    <= w_gnt_idx;
        if (w_gnt_entry.last) begin
          r_last_seen[w_gnt_idx] <= 1'b1;
        end
        if (r_wr_count != '1) begin
          r_wr_count <= r_wr_count + 16'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_ch_en     <= ch_en_i;
            r_base      <= out_base_i;
            r_last_seen <= '0;
            r_ovf       <= '0;
            r_wr_count  <= '0;
          end
        end
        S_RUN: begin
          if (w_all_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((&w_empty) && !r_wea) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wea_o      = r_wea;
  assign addra_o    = r_addra;
  assign dia_o      = r_dia;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign overflow_o = r_ovf;
  assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_pool_wb_arbiter.sv
// Scoreboard bench for pool_wb_arbiter: directed layers push hand-ordered expected writes,
// a forked monitor pops and compares on every wea_o and checks the queue is empty at done_o.
module tb_pool_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [5:0]  ch_en_i = '0;
  logic [16:0] out_base_i = '0;
  logic [5:0]  pool_valid_i = '0;
  logic [5:0]  pool_last_i = '0;
  logic [47:0] pool_data_i = '0;
  logic [47:0] pool_addr_i = '0;
  logic [5:0]  pool_ready_o;
  logic        wea_o;
  logic [16:0] addra_o;
  logic [7:0]  dia_o;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  overflow_o;
  logic [15:0] wr_count_o;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_cnt = 0;

  pool_wb_arbiter #(
    .POOL_NUM   (6),
    .DATA_WIDTH (8),
    .PADDR_W    (8),
    .ADDR_W     (17),
    .CH_SHIFT   (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .ch_en_i      (ch_en_i),
    .out_base_i   (out_base_i),
    .pool_valid_i (pool_valid_i),
    .pool_last_i  (pool_last_i),
    .pool_data_i  (pool_data_i),
    .pool_addr_i  (pool_addr_i),
    .pool_ready_o (pool_ready_o),
    .wea_o        (wea_o),
    .addra_o      (addra_o),
    .dia_o        (dia_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .wr_count_o   (wr_count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] ln(input int k, input logic [7:0] v);
    return {40'b0, v} << (8 * k);
  endfunction

  task automatic exp_wr(input int ch, input logic [16:0] base, input logic [7:0] addr,
                        input logic [7:0] data);
    wr_t w;
    w.a = base + 17'(ch << 8) + 17'(addr);
    w.d = data;
    exp_q.push_back(w);
  endtask

  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      if (done_o) begin
        done_cnt++;
        chk("done_queue_left", exp_q.size(), 0);
      end
      if (wea_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addra_o, dia_o);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", addra_o, w.a);
          chk("wr_data", dia_o, w.d);
        end
      end
    end
  endtask

  task automatic put(input logic [5:0] v, input logic [5:0] l, input logic [47:0] d,
                     input logic [47:0] a);
    @(negedge clk);
    pool_valid_i = v;
    pool_last_i  = l;
    pool_data_i  = d;
    pool_addr_i  = a;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pool_valid_i = '0;
      pool_last_i  = '0;
    end
  endtask

  task automatic start(input logic [5:0] en, input logic [16:0] base);
    @(negedge clk);
    pool_valid_i = '0;
    pool_last_i  = '0;
    start_i      = 1'b1;
    ch_en_i      = en;
    out_base_i   = base;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c0;
    c0 = done_cnt;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done_cnt != c0) break;
    end
    idle(3);
    chk(name, done_cnt - c0, 1);
  endtask

  initial begin
    logic [47:0] d;
    logic [47:0] a;
    fork
      monitor();
    join_none

    // 1: reset state, single-channel 196-result layer
    repeat (3) @(negedge clk);
    chk("rst_wea", wea_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ready", pool_ready_o, 6'h3F);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_wrcnt", wr_count_o, 0);
    chk("rst_addra", addra_o, 0);
    rst = 1'b0;
    start(6'h01, 17'h18000);
    chk("t1_busy", busy_o, 1);
    for (int i = 0; i < 196; i++) begin
      put(6'h01, (i == 195) ? 6'h01 : 6'h00, ln(0, 8'(i) ^ 8'hA5), ln(0, 8'(i)));
      exp_wr(0, 17'h18000, 8'(i), 8'(i) ^ 8'hA5);
      if (i == 1) chk("t1_lat_early", wea_o, 0);
      if (i == 2) begin
        chk("t1_lat_wea", wea_o, 1);
        chk("t1_lat_addr", addra_o, 17'h18000);
      end
    end
    idle(1);
    wait_done(20, "t1_done_once");
    chk("t1_wrcnt", wr_count_o, 196);
    chk("t1_busy_end", busy_o, 0);

    // 2: all six valid together; a prior pool5 grant makes the sweep start at 0
    start(6'h3F, 17'h00100);
    put(6'h20, 6'h00, ln(5, 8'h55), ln(5, 8'h09));
    exp_wr(5, 17'h00100, 8'h09, 8'h55);
    idle(4);
    d = '0; a = '0;
    for (int k = 0; k < 6; k++) begin
      d |= ln(k, 8'(k));
      a |= ln(k, 8'h05);
      exp_wr(k, 17'h00100, 8'h05, 8'(k));
    end
    put(6'h3F, 6'h00, d, a);
    idle(1);
    for (int j = 0; j < 6; j++) begin
      idle(1);
      chk("t2_consecutive", wea_o, 1);
    end
    d = '0; a = '0;
    for (int k = 0; k < 6; k++) begin
      d |= ln(k, 8'h80 + 8'(k));
      a |= ln(k, 8'hC3);
      exp_wr(k, 17'h00100, 8'hC3, 8'h80 + 8'(k));
    end
    put(6'h3F, 6'h3F, d, a);
    idle(1);
    wait_done(30, "t2_done_once");
    chk("t2_wrcnt", wr_count_o, 13);

    // 3: pool2 starved behind the others; fifth valid overflows
    start(6'h3F, 17'h04000);
    put(6'h04, 6'h00, ln(2, 8'h77), ln(2, 8'h11));
    exp_wr(2, 17'h04000, 8'h11, 8'h77);
    idle(4);
    d = '0; a = '0;
    for (int k = 0; k < 6; k++) begin
      d |= ln(k, (k == 2) ? 8'h20 : 8'h30 + 8'(k));
      a |= ln(k, (k == 2) ? 8'h00 : 8'h40 + 8'(k));
    end
    exp_wr(3, 17'h04000, 8'h43, 8'h33);
    exp_wr(4, 17'h04000, 8'h44, 8'h34);
    exp_wr(5, 17'h04000, 8'h45, 8'h35);
    exp_wr(0, 17'h04000, 8'h40, 8'h30);
    exp_wr(1, 17'h04000, 8'h41, 8'h31);
    for (int j = 0; j < 4; j++) exp_wr(2, 17'h04000, 8'(j), 8'h20 + 8'(j));
    put(6'h3F, 6'h00, d, a);
    for (int j = 1; j < 5; j++) begin
      put(6'h04, 6'h00, ln(2, 8'h20 + 8'(j)), ln(2, 8'(j)));
      if (j == 3) chk("t3_ready_cnt3", pool_ready_o, 6'h3F);
      if (j == 4) begin
        chk("t3_ready_full", pool_ready_o, 6'h3B);
        chk("t3_ovf_before", overflow_o, 6'h00);
      end
    end
    idle(1);
    chk("t3_ovf_set", overflow_o, 6'h04);
    chk("t3_ready_still", pool_ready_o, 6'h3B);
    idle(8);
    d = '0; a = '0;
    for (int k = 0; k < 6; k++) begin
      d |= ln(k, 8'h90 + 8'(k));
      a |= ln(k, 8'hC3);
    end
    for (int j = 0; j < 6; j++) exp_wr((j + 3) % 6, 17'h04000, 8'hC3, 8'h90 + 8'((j + 3) % 6));
    put(6'h3F, 6'h3F, d, a);
    idle(1);
    wait_done(30, "t3_done_once");
    chk("t3_ovf_sticky", overflow_o, 6'h04);
    chk("t3_wrcnt", wr_count_o, 16);

    // 4: pool1 last arrives while pools 3,4 are still queued
    start(6'h1A, 17'h08000);
    chk("t4_ovf_clr", overflow_o, 0);
    chk("t4_wrcnt_clr", wr_count_o, 0);
    exp_wr(3, 17'h08000, 8'h01, 8'h31);
    exp_wr(4, 17'h08000, 8'h01, 8'h41);
    exp_wr(1, 17'h08000, 8'h10, 8'h1F);
    exp_wr(3, 17'h08000, 8'h02, 8'h32);
    exp_wr(4, 17'h08000, 8'h02, 8'h42);
    put(6'h18, 6'h00, ln(3, 8'h31) | ln(4, 8'h41), ln(3, 8'h01) | ln(4, 8'h01));
    put(6'h18, 6'h18, ln(3, 8'h32) | ln(4, 8'h42), ln(3, 8'h02) | ln(4, 8'h02));
    put(6'h02, 6'h02, ln(1, 8'h1F), ln(1, 8'h10));
    idle(1);
    chk("t4_busy_pending", busy_o, 1);
    wait_done(30, "t4_done_once");
    chk("t4_wrcnt", wr_count_o, 5);

    // 5: reset mid-RUN with loaded FIFOs, then a clean layer
    start(6'h3F, 17'h0C000);
    d = '0; a = '0;
    for (int k = 0; k < 6; k++) begin
      d |= ln(k, 8'h60 + 8'(k));
      a |= ln(k, 8'(k));
    end
    put(6'h3F, 6'h00, d, a);
    @(negedge clk);
    pool_valid_i = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_wea", wea_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_ready", pool_ready_o, 6'h3F);
    chk("t5_wrcnt", wr_count_o, 0);
    rst = 1'b0;
    start(6'h01, 17'h00040);
    exp_wr(0, 17'h00040, 8'h07, 8'h5A);
    exp_wr(0, 17'h00040, 8'h08, 8'hA5);
    put(6'h01, 6'h00, ln(0, 8'h5A), ln(0, 8'h07));
    put(6'h01, 6'h01, ln(0, 8'hA5), ln(0, 8'h08));
    idle(1);
    wait_done(30, "t5_done_once");
    chk("t5_wrcnt_clean", wr_count_o, 2);

    // 6: start during RUN is ignored; empty-channel layer
    start(6'h01, 17'h01000);
    start(6'h3F, 17'h02000);
    exp_wr(0, 17'h01000, 8'h03, 8'h11);
    put(6'h03, 6'h03, ln(0, 8'h11) | ln(1, 8'h22), ln(0, 8'h03) | ln(1, 8'h04));
    idle(1);
    wait_done(30, "t6_done_once");
    chk("t6_wrcnt", wr_count_o, 1);
    @(negedge clk);
    start_i = 1'b1;
    ch_en_i = 6'h00;
    out_base_i = 17'h00000;
    @(negedge clk);
    start_i = 1'b0;
    chk("t6_run_busy", busy_o, 1);
    chk("t6_run_done", done_o, 0);
    @(negedge clk);
    chk("t6_drain_done", done_o, 0);
    @(negedge clk);
    chk("t6_done_pulse", done_o, 1);
    chk("t6_done_busy", busy_o, 0);
    @(negedge clk);
    chk("t6_done_end", done_o, 0);
    chk("t6_nowrites", wr_count_o, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
